exa_crosb_e2s_with_vcs: RTL and testbench

- Receive side of the ExaNet/AXI-Stream bridge; inverse of the s2e converter.
- Accepts one ExaNet packet at a time (header, then payload words, then footer) tagged with a VC index. Re-serialises it as one AXI-Stream frame: header beat, payload beats, footer beat with TLAST.
- A shared elastic output FIFO decouples ExaNet ingress from AXIS TREADY.
- A per-VC stall vector from the downstream endpoint blocks new packets on stalled VCs.

---
 rtl/exa_crosb_e2s_with_vcs.sv | 162 ++++++++++++++++
 tb/tb_exa_crosb_e2s_with_vcs.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exa_crosb_e2s_with_vcs.sv
// ExaNet-to-AXI-Stream receive bridge: serialises header/payload/footer packets tagged with a
// VC into single AXIS frames through a shared elastic output FIFO.
module exa_crosb_e2s_with_vcs #(
  parameter int unsigned prio_num       = 2,
  parameter int unsigned vc_num         = 2,
  parameter int unsigned data_width     = 128,
  parameter int unsigned out_fifo_depth = 72,
  parameter int unsigned len_msb        = 7
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [((prio_num*vc_num > 1) ? $clog2(prio_num*vc_num) : 1)-1:0] i_vc,
  input  logic [prio_num*vc_num-1:0]                       i_vc_stall,
  input  logic [data_width-1:0]                            i_header,
  input  logic                                             i_header_valid,
  output logic                                             o_header_ready,
  input  logic [data_width-1:0]                            i_payload,
  input  logic                                             i_payload_valid,
  input  logic                                             i_payload_last,
  output logic                                             o_payload_ready,
  input  logic [data_width-1:0]                            i_footer,
  input  logic                                             i_footer_valid,
  output logic                                             o_footer_ready,
  output logic [data_width-1:0]                            M_AXIS_TDATA,
  output logic                                             M_AXIS_TVALID,
  output logic                                             M_AXIS_TLAST,
  input  logic                                             M_AXIS_TREADY,
  output logic [((prio_num*vc_num > 1) ? $clog2(prio_num*vc_num) : 1)-1:0] o_output_vc,
  output logic                                             o_len_err,
  output logic [15:0]                                      o_pkt_cnt
);

  localparam int unsigned VT   = prio_num * vc_num;
  localparam int unsigned VcW  = (VT > 1) ? $clog2(VT) : 1;
  localparam int unsigned PtrW = $clog2(out_fifo_depth);
  localparam int unsigned CntW = $clog2(out_fifo_depth + 1);
  localparam int unsigned EntW = data_width + VcW + 1;

  typedef enum logic [1:0] {StIdle, StPay, StFtr} state_e;

  state_e            state_q;
  logic [VcW-1:0]    vc_q;
  logic [len_msb:0]  len_q;
  logic [len_msb:0]  beat_q;
  logic              over_q;
  logic              len_err_q;
  logic [15:0]       pkt_cnt_q;

  logic [EntW-1:0]   mem [out_fifo_depth];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic              fifo_valid;
  logic              pop;
  logic              push;
  logic              has_space;
  logic              vc_stalled;
  logic              hdr_hs;
  logic              pay_hs;
  logic              ftr_hs;
  logic [EntW-1:0]   push_entry;
  logic [EntW-1:0]   head;

  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && M_AXIS_TREADY;
  // Space is judged after this cycle's pop so a full FIFO still streams at one beat per cycle.
  assign has_space  = (count_q != CntW'(out_fifo_depth)) || pop;

  always_comb begin
    vc_stalled = 1'b1;
    if (32'(i_vc) < VT) vc_stalled = i_vc_stall[i_vc];
  end

  assign o_header_ready  = !reset && (state_q == StIdle) && !vc_stalled && has_space;
  assign o_payload_ready = !reset && (state_q == StPay) && has_space;
  assign o_footer_ready  = !reset && (state_q == StFtr) && has_space;

  assign hdr_hs = i_header_valid && o_header_ready;
  assign pay_hs = i_payload_valid && o_payload_ready;
  assign ftr_hs = i_footer_valid && o_footer_ready;
  assign push   = hdr_hs || pay_hs || ftr_hs;

  always_comb begin
    push_entry = {1'b0, vc_q, i_payload};
    if (hdr_hs) push_entry = {1'b0, i_vc, i_header};
    if (ftr_hs) push_entry = {1'b1, vc_q, i_footer};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(out_fifo_depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(out_fifo_depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (head[EntW-1]) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      vc_q      <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      over_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (hdr_hs) begin
            vc_q    <= i_vc;
            len_q   <= i_header[len_msb:0];
            beat_q  <= '0;
            over_q  <= 1'b0;
            state_q <= (i_header[len_msb:0] == '0) ? StFtr : StPay;
          end
        end
        StPay: begin
          if (pay_hs) begin
            beat_q <= beat_q + 1'b1;
            if (i_payload_last) begin
              state_q   <= StFtr;
              len_err_q <= over_q || (beat_q + 1'b1 != len_q);
            end else if (beat_q + 1'b1 == len_q) begin
              // Overrun: remember it so the error still fires if the count later wraps onto L.
              over_q <= 1'b1;
            end
          end
        end
        StFtr: begin
          if (ftr_hs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign head          = mem[rd_ptr_q];
  assign M_AXIS_TVALID = fifo_valid;
  assign M_AXIS_TDATA  = fifo_valid ? head[data_width-1:0] : '0;
  assign M_AXIS_TLAST  = fifo_valid && head[EntW-1];
  assign o_output_vc   = fifo_valid ? head[EntW-2 -: VcW] : '0;
  assign o_len_err     = len_err_q;
  assign o_pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_exa_crosb_e2s_with_vcs.sv
// Randomised bench for exa_crosb_e2s_with_vcs: a queue of expected AXIS beats and a packet-phase
// model predict readies, output beats, length errors and the frame counter every cycle.
module tb_exa_crosb_e2s_with_vcs;

  localparam int DEPTH = 8;
  localparam int DW    = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    i_vc;
  logic [3:0]    i_vc_stall;
  logic [DW-1:0] i_header, i_payload, i_footer;
  logic          i_header_valid, i_payload_valid, i_payload_last, i_footer_valid;
  logic          o_header_ready, o_payload_ready, o_footer_ready;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic [1:0]    o_output_vc;
  logic          o_len_err;
  logic [15:0]   o_pkt_cnt;

  always #5 clk = ~clk;

  exa_crosb_e2s_with_vcs #(
    .prio_num      (2),
    .vc_num        (2),
    .data_width    (DW),
    .out_fifo_depth(DEPTH),
    .len_msb       (7)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_vc           (i_vc),
    .i_vc_stall     (i_vc_stall),
    .i_header       (i_header),
    .i_header_valid (i_header_valid),
    .o_header_ready (o_header_ready),
    .i_payload      (i_payload),
    .i_payload_valid(i_payload_valid),
    .i_payload_last (i_payload_last),
    .o_payload_ready(o_payload_ready),
    .i_footer       (i_footer),
    .i_footer_valid (i_footer_valid),
    .o_footer_ready (o_footer_ready),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .o_output_vc    (o_output_vc),
    .o_len_err      (o_len_err),
    .o_pkt_cnt      (o_pkt_cnt)
  );

  typedef struct packed {
    logic          last;
    logic [1:0]    vc;
    logic [DW-1:0] data;
  } beat_t;

  int total = 0;
  int bad   = 0;

  beat_t         exp_q[$];
  int            ph;        // 0 header, 1 payload, 2 footer
  int            pk_vc, pk_len, pk_nw, pay_idx;
  logic [DW-1:0] hdr_w, pay_w, ftr_w;
  logic [15:0]   pkt_cnt_m;
  logic          err_m;
  bit            just_rst;
  int            tready_pct;
  int            stall_pct;
  bit            stall_fixed;
  logic [3:0]    stall_val;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_pkt(input int vc, input int len, input int nw);
    pk_vc   = vc;
    pk_len  = len;
    pk_nw   = nw;
    pay_idx = 0;
    hdr_w   = rand_word();
    hdr_w[7:0] = 8'(len);
    pay_w   = rand_word();
    ftr_w   = rand_word();
    ph      = 0;
  endtask

  task automatic rand_pkt();
    int len, nw;
    len = $urandom_range(0, 12);
    nw  = len;
    if (len != 0 && $urandom_range(0, 5) == 0) nw = $urandom_range(1, len + 2);
    new_pkt($urandom_range(0, 3), len, nw);
  endtask

  task automatic do_cycle(input bit rst);
    bit    space, er_h, er_p, er_f;
    beat_t b;
    @(negedge clk);
    reset           = rst;
    M_AXIS_TREADY   = ($urandom_range(0, 99) < tready_pct);
    if (stall_fixed) i_vc_stall = stall_val;
    else i_vc_stall = ($urandom_range(0, 99) < stall_pct) ? 4'($urandom) : 4'd0;
    i_vc            = 2'(pk_vc);
    i_header        = hdr_w;
    i_payload       = pay_w;
    i_footer        = ftr_w;
    i_payload_last  = (pay_idx == pk_nw - 1);
    i_header_valid  = !rst && ph == 0 && $urandom_range(0, 9) < 7;
    i_payload_valid = !rst && ((ph == 1 && $urandom_range(0, 9) < 7) ||
                               (ph == 2 && pk_len == 0 && $urandom_range(0, 1) == 1));
    i_footer_valid  = !rst && ph == 2 && $urandom_range(0, 9) < 7;
    #1;
    if (rst) begin
      check_eq("rst_hdr_ready", DW'(o_header_ready), '0);
      check_eq("rst_pay_ready", DW'(o_payload_ready), '0);
      check_eq("rst_ftr_ready", DW'(o_footer_ready), '0);
      exp_q.delete();
      pkt_cnt_m = '0;
      err_m     = 1'b0;
      just_rst  = 1'b1;
      rand_pkt();
      return;
    end
    if (just_rst) begin
      check_eq("rst_tlast", DW'(M_AXIS_TLAST), '0);
      check_eq("rst_out_vc", DW'(o_output_vc), '0);
      just_rst = 1'b0;
    end
    space = (exp_q.size() < DEPTH) || (exp_q.size() > 0 && M_AXIS_TREADY);
    er_h  = (ph == 0) && !i_vc_stall[pk_vc] && space;
    er_p  = (ph == 1) && space;
    er_f  = (ph == 2) && space;
    check_eq("hdr_ready", DW'(o_header_ready), DW'(er_h));
    check_eq("pay_ready", DW'(o_payload_ready), DW'(er_p));
    check_eq("ftr_ready", DW'(o_footer_ready), DW'(er_f));
    check_eq("tvalid", DW'(M_AXIS_TVALID), DW'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_eq("tdata", M_AXIS_TDATA, exp_q[0].data);
      check_eq("tlast", DW'(M_AXIS_TLAST), DW'(exp_q[0].last));
      check_eq("out_vc", DW'(o_output_vc), DW'(exp_q[0].vc));
    end
    check_eq("len_err", DW'(o_len_err), DW'(err_m));
    check_eq("pkt_cnt", DW'(o_pkt_cnt), DW'(pkt_cnt_m));

    err_m = 1'b0;
    if (exp_q.size() > 0 && M_AXIS_TREADY) begin
      if (exp_q[0].last) pkt_cnt_m++;
      void'(exp_q.pop_front());
    end
    if (ph == 0 && i_header_valid && er_h) begin
      b = '{last: 1'b0, vc: 2'(pk_vc), data: hdr_w};
      exp_q.push_back(b);
      ph = (pk_len == 0) ? 2 : 1;
    end else if (ph == 1 && i_payload_valid && er_p) begin
      b = '{last: 1'b0, vc: 2'(pk_vc), data: pay_w};
      exp_q.push_back(b);
      if (pay_idx == pk_nw - 1) begin
        err_m = (pk_nw != pk_len);
        ph    = 2;
      end else begin
        pay_idx++;
        pay_w = rand_word();
      end
    end else if (ph == 2 && i_footer_valid && er_f) begin
      b = '{last: 1'b1, vc: 2'(pk_vc), data: ftr_w};
      exp_q.push_back(b);
      rand_pkt();
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0);
  endtask

  task automatic wait_boundary();
    for (int i = 0; i < 300 && ph != 0; i++) do_cycle(1'b0);
    check_eq("boundary_wait", DW'(ph), '0);
  endtask

  initial begin
    reset = 1'b1;
    i_vc = '0; i_vc_stall = '0; i_header = '0; i_payload = '0; i_footer = '0;
    i_header_valid = 1'b0; i_payload_valid = 1'b0; i_payload_last = 1'b0;
    i_footer_valid = 1'b0; M_AXIS_TREADY = 1'b0;
    tready_pct = 100; stall_pct = 0; stall_fixed = 1'b0; stall_val = '0;
    just_rst = 1'b0;
    rand_pkt();

    do_cycle(1'b1);
    do_cycle(1'b1);
    new_pkt(2, 3, 3);
    run(15);

    wait_boundary();
    new_pkt(2, 2, 2);
    stall_fixed = 1'b1; stall_val = 4'b0100;
    run(5);
    stall_val = 4'b0000;
    run(12);
    stall_fixed = 1'b0;

    wait_boundary();
    new_pkt(1, 10, 10);
    tready_pct = 0;
    run(30);
    tready_pct = 100;
    run(20);

    wait_boundary();
    new_pkt(0, 2, 3);
    run(12);
    wait_boundary();
    new_pkt(3, 2, 1);
    run(12);
    wait_boundary();
    new_pkt(0, 0, 0);
    run(10);

    tready_pct = 70; stall_pct = 20;
    run(3000);

    tready_pct = 100; stall_pct = 0;
    wait_boundary();
    new_pkt(1, 5, 5);
    for (int i = 0; i < 100 && !(ph == 1 && pay_idx == 2); i++) do_cycle(1'b0);
    do_cycle(1'b1);
    run(60);

    tready_pct = 50;
    run(500);
    tready_pct = 100;
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
